// File: rtl/riscv_pkg.sv
// ---------------------------------------------------------------------------
// riscv_pkg
// Shared constants for the fetch front end and the decode/control stage:
//   - RV32 base opcode values
//   - fetch FSM state encoding
//   - bit positions of the instruction fields pre-split by fetch
// ---------------------------------------------------------------------------
package riscv_pkg;

    // Base opcodes (instr[6:0])
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    // Fetch FSM state encoding
    typedef logic [1:0] fetch_state_t;
    localparam fetch_state_t S_IDLE  = 2'd0;
    localparam fetch_state_t S_FETCH = 2'd1;
    localparam fetch_state_t S_FULL  = 2'd2;

    // Field slice positions
    localparam int OPC_LSB = 0;
    localparam int OPC_MSB = 6;
    localparam int F3_LSB  = 12;
    localparam int F3_MSB  = 14;
    // mod = {instr[MOD_HI], instr[MOD_LO]}: funct7[5] (sub/sra) and funct7[0] (M ext)
    localparam int MOD_HI  = 30;
    localparam int MOD_LO  = 25;

endpackage

// File: rtl/sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
// Single-clock circular-buffer FIFO with synchronous reset and flush.
// Ports:
//   i_clk    clock, rising edge
//   i_rst    synchronous active-high reset (pointers and count only)
//   i_flush  synchronous clear, same effect as reset
//   i_push   write i_wdata at the tail
//   i_wdata  write data, DATA_W bits
//   i_pop    advance the head (ignored when empty)
//   o_rdata  head entry, combinational
//   o_empty  no entries
//   o_count  number of entries, 0..DEPTH
// Push and pop together keep the count unchanged, also when full.
// ---------------------------------------------------------------------------
module sync_fifo #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_flush,
    input  logic                     i_push,
    input  logic [DATA_W-1:0]        i_wdata,
    input  logic                     i_pop,
    output logic [DATA_W-1:0]        o_rdata,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;

    logic w_full;
    logic w_do_pop;
    logic w_do_push;

    assign w_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign w_do_pop  = i_pop && !o_empty;
    // A pop frees the head slot in the same cycle, so a push into a full FIFO is fine then
    assign w_do_push = i_push && (!w_full || w_do_pop);

    assign o_rdata = r_mem[r_rd_ptr];
    assign o_count = r_count;

    // Control: pointers and count
    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Data storage, not reset
    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // Upstream credit accounting must make this impossible
    always_ff @(posedge i_clk) begin
        if (!i_rst && !i_flush) begin
            assert (!(i_push && !i_pop && w_full));
        end
    end

endmodule

// File: rtl/instr_fetch_queue.sv
// ---------------------------------------------------------------------------
// instr_fetch_queue
// Instruction fetch front end: sequential PC generation, requests to a
// fixed one-cycle-latency instruction memory, a small FIFO of returned
// {pc, instr} pairs, and a valid/ready interface to decode with the
// opcode/funct3/mod fields pre-split. A redirect flushes and restarts.
// Ports:
//   clk, reset          clock and synchronous active-high reset
//   imem_req/imem_addr  fetch request and word-aligned address
//   imem_rvalid/rdata   response, exactly one cycle after a request
//   redirect_valid/pc   taken jump/branch target from execute
//   dec_ready           decode accepts the head entry
//   dec_valid           head entry valid
//   dec_pc/dec_instr    head PC and raw instruction (0 when empty)
//   dec_opcode/funct3/mod  fields sliced from dec_instr
//   occupancy           current FIFO entries
// ---------------------------------------------------------------------------
module instr_fetch_queue
    import riscv_pkg::*;
#(
    parameter int              DEPTH    = 4,
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic                     clk,
    input  logic                     reset,
    output logic                     imem_req,
    output logic [XLEN-1:0]          imem_addr,
    input  logic                     imem_rvalid,
    input  logic [XLEN-1:0]          imem_rdata,
    input  logic                     redirect_valid,
    input  logic [XLEN-1:0]          redirect_pc,
    input  logic                     dec_ready,
    output logic                     dec_valid,
    output logic [XLEN-1:0]          dec_pc,
    output logic [XLEN-1:0]          dec_instr,
    output logic [6:0]               dec_opcode,
    output logic [2:0]               dec_funct3,
    output logic [1:0]               dec_mod,
    output logic [$clog2(DEPTH):0]   occupancy
);

    localparam int            CW      = $clog2(DEPTH) + 1;
    localparam logic [CW:0]   DEPTH_W = (CW+1)'(DEPTH);

    fetch_state_t      r_state;
    fetch_state_t      w_state_nxt;
    logic [XLEN-1:0]   r_pc;
    logic [XLEN-1:0]   r_req_pc;
    logic              r_inflight;
    logic              r_squash;

    logic              w_req;
    logic              w_push;
    logic              w_pop;
    logic              w_credit;
    logic [CW:0]       w_credit_sum;
    logic              w_fifo_empty;
    logic [CW-1:0]     w_count;
    logic [2*XLEN-1:0] w_head;
    logic [XLEN-1:0]   w_redirect_pc;

    assign w_redirect_pc = redirect_pc & ~XLEN'(3);

    // Head handshake; nothing is presented while reset is held
    assign dec_valid = !w_fifo_empty && !reset;
    assign w_pop     = dec_valid && dec_ready;

    // Entries that will exist next cycle if we issue now: queued + arriving - leaving.
    // Issue only while that stays below DEPTH so the response always has a slot.
    assign w_credit_sum = {1'b0, w_count} + (CW+1)'(r_inflight) - (CW+1)'(w_pop);
    assign w_credit     = (w_credit_sum < DEPTH_W);

    assign w_req     = !reset && (r_state == S_FETCH) && w_credit;
    assign imem_req  = w_req;
    assign imem_addr = reset ? RESET_PC : r_pc;

    // Responses to a request made before a redirect/reset are dropped
    assign w_push = imem_rvalid && !r_squash && !redirect_valid && !reset;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  w_state_nxt = S_FETCH;
            S_FETCH: w_state_nxt = w_credit ? S_FETCH : S_FULL;
            S_FULL:  w_state_nxt = w_credit ? S_FETCH : S_FULL;
            default: w_state_nxt = S_IDLE;
        endcase
        if (redirect_valid) begin
            w_state_nxt = S_FETCH;
        end
    end

    // Control state
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_pc       <= RESET_PC;
            r_inflight <= 1'b0;
            r_squash   <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_inflight <= w_req && !redirect_valid;
            r_squash   <= redirect_valid;
            if (redirect_valid) begin
                r_pc <= w_redirect_pc;
            end else if (w_req) begin
                r_pc <= r_pc + XLEN'(4);
            end
        end
    end

    // PC of the outstanding request, paired with its response
    always_ff @(posedge clk) begin
        if (w_req) begin
            r_req_pc <= r_pc;
        end
    end

    sync_fifo #(
        .DATA_W (2*XLEN),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .i_clk   (clk),
        .i_rst   (reset),
        .i_flush (redirect_valid),
        .i_push  (w_push),
        .i_wdata ({r_req_pc, imem_rdata}),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_empty (w_fifo_empty),
        .o_count (w_count)
    );

    // Head fields, forced to zero when nothing is valid
    assign dec_pc     = dec_valid ? w_head[2*XLEN-1:XLEN] : '0;
    assign dec_instr  = dec_valid ? w_head[XLEN-1:0]      : '0;
    assign dec_opcode = dec_instr[OPC_MSB:OPC_LSB];
    assign dec_funct3 = dec_instr[F3_MSB:F3_LSB];
    assign dec_mod    = {dec_instr[MOD_HI], dec_instr[MOD_LO]};
    assign occupancy  = w_count;

endmodule
